// File: rtl/modbus_frame_scheduler_pkg.sv
// Shared types and constants for the Modbus RTU frame scheduler and CRC logic.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package modbus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CRC,
        SEND,
        NEXT,
        GAP
    } state_t;

    localparam logic [15:0] CRC_INIT    = 16'hFFFF;
    localparam logic [15:0] CRC_POLY    = 16'hA001;
    localparam int          FRAME_LEN   = 7;
    localparam int          PAYLOAD_LEN = 5;

    // One LSB-first step of the reflected Modbus CRC-16. The incoming bit is
    // folded into the LSB before the shift, which matches the byte-wise
    // "xor byte into low half, then shift eight times" formulation.
    function automatic logic [15:0] crc16_bit_step(input logic [15:0] crc_in,
                                                   input logic        din);
        logic fb;
        fb = crc_in[0] ^ din;
        crc16_bit_step = {1'b0, crc_in[15:1]} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/modbus_frame_scheduler_if.sv
// Requester + byte-transmitter side signals of the Modbus frame scheduler.
// Ports: Req_Sig/Req_Data/BPS_CLK/TX_Done_Sig into the scheduler,
// TX_En_Sig/TX_Data/Busy_Sig/Frame_Done_Sig/Drop_Sig out of it.
interface modbus_frame_scheduler_if;

    logic       Req_Sig;
    logic [7:0] Req_Data;
    logic       BPS_CLK;
    logic       TX_Done_Sig;
    logic       TX_En_Sig;
    logic [7:0] TX_Data;
    logic       Busy_Sig;
    logic       Frame_Done_Sig;
    logic       Drop_Sig;

    // master: the scheduler itself
    modport master (
        input  Req_Sig, Req_Data, BPS_CLK, TX_Done_Sig,
        output TX_En_Sig, TX_Data, Busy_Sig, Frame_Done_Sig, Drop_Sig
    );

    // slave: requester / transmitter environment around the scheduler
    modport slave (
        output Req_Sig, Req_Data, BPS_CLK, TX_Done_Sig,
        input  TX_En_Sig, TX_Data, Busy_Sig, Frame_Done_Sig, Drop_Sig
    );

endinterface

// File: rtl/modbus_crc16_serial.sv
// Bit-serial Modbus CRC-16 (init FFFF, reflected poly A001), LSB first.
// Latency: one CLK per bit; crc reflects the bit on the following cycle.
// Backpressure: none; bit_en gates the update, clear restores the init value.
module modbus_crc16_serial
    import modbus_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        clear,
    input  logic        bit_en,
    input  logic        data_bit,
    output logic [15:0] crc
);

    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            crc <= CRC_INIT;
        end else if (bit_en) begin
            crc <= crc16_bit_step(crc, data_bit);
        end
    end

endmodule

// File: rtl/modbus_frame_scheduler.sv
// Sequences the byte UART into one 7-byte Modbus RTU frame per request, with
// hardware CRC, inter-frame silence and a one-deep pending request slot.
// Latency: first byte enabled 41 cycles after Req_Sig (40 CRC cycles).
// Backpressure: each byte held until TX_Done_Sig; extra requests dropped when slot full.
// Ports: CLK, RST (sync, active-high), bus (master modport of modbus_frame_scheduler_if).
module modbus_frame_scheduler
    import modbus_pkg::*;
#(
    parameter logic [7:0]  SLAVE_ADDR = 8'h02,
    parameter logic [7:0]  FUNC_CODE  = 8'h02,
    parameter logic [7:0]  DATA2      = 8'h00,
    parameter logic [7:0]  DATA1      = 8'h00,
    parameter int unsigned GAP_BITS   = 39
)(
    input  logic                      CLK,
    input  logic                      RST,
    modbus_frame_scheduler_if.master  bus
);

    localparam logic [5:0] GAP_LAST  = 6'(GAP_BITS);
    localparam logic [5:0] CRC_LAST  = 6'(PAYLOAD_LEN * 8 - 1);
    localparam logic [2:0] BYTE_LAST = 3'(FRAME_LEN - 1);

    state_t      state;
    logic [2:0]  byte_idx;
    logic [5:0]  bit_cnt;
    logic [5:0]  gap_cnt;
    logic [7:0]  data0;
    logic        pend_vld;
    logic [7:0]  pend_dat;

    logic        tx_en_q;
    logic [7:0]  tx_data_q;
    logic        busy_q;
    logic        frame_done_q;
    logic        drop_q;

    logic [15:0] crc;
    logic        crc_clear;
    logic        crc_bit_en;
    logic        crc_din;
    logic [7:0]  crc_byte;
    logic [5:0]  gap_nxt;
    logic        gap_final;

    // Bytes 0..4 of the frame: the fixed header plus the captured payload byte.
    function automatic logic [7:0] payload_byte(input logic [2:0] idx,
                                                input logic [7:0] d0);
        case (idx)
            3'd0:    payload_byte = SLAVE_ADDR;
            3'd1:    payload_byte = FUNC_CODE;
            3'd2:    payload_byte = DATA2;
            3'd3:    payload_byte = DATA1;
            default: payload_byte = d0;
        endcase
    endfunction

    // Full frame: CRC goes out low byte first.
    function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                              input logic [7:0]  d0,
                                              input logic [15:0] c);
        case (idx)
            3'd5:    frame_byte = c[7:0];
            3'd6:    frame_byte = c[15:8];
            default: frame_byte = payload_byte(idx, d0);
        endcase
    endfunction

    // bit_cnt[5:3] walks bytes 0..4, bit_cnt[2:0] walks bits LSB first.
    assign crc_byte   = payload_byte(bit_cnt[5:3], data0);
    assign crc_din    = crc_byte[bit_cnt[2:0]];
    assign crc_bit_en = (state == CRC);
    // The CRC is only read while sending, so it can sit at its init value
    // whenever no frame is being computed or transmitted.
    assign crc_clear  = (state == IDLE) || (state == GAP);

    assign gap_nxt   = (gap_cnt >= GAP_LAST) ? GAP_LAST : gap_cnt + 6'd1;
    assign gap_final = bus.BPS_CLK && (gap_nxt == GAP_LAST);

    modbus_crc16_serial u_crc (
        .CLK      (CLK),
        .RST      (RST),
        .clear    (crc_clear),
        .bit_en   (crc_bit_en),
        .data_bit (crc_din),
        .crc      (crc)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            byte_idx     <= 3'd0;
            bit_cnt      <= 6'd0;
            gap_cnt      <= 6'd0;
            data0        <= 8'h00;
            pend_vld     <= 1'b0;
            pend_dat     <= 8'h00;
            tx_en_q      <= 1'b0;
            tx_data_q    <= 8'h00;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            drop_q       <= 1'b0;

            // Requests arriving mid-frame go to the pending slot; the GAP exit
            // branch below may override this when it consumes the slot.
            if (state != IDLE && bus.Req_Sig) begin
                if (!pend_vld) begin
                    pend_vld <= 1'b1;
                    pend_dat <= bus.Req_Data;
                end else begin
                    drop_q <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (bus.Req_Sig) begin
                        data0   <= bus.Req_Data;
                        bit_cnt <= 6'd0;
                        busy_q  <= 1'b1;
                        state   <= CRC;
                    end
                end

                CRC: begin
                    bit_cnt <= bit_cnt + 6'd1;
                    if (bit_cnt == CRC_LAST) begin
                        bit_cnt   <= 6'd0;
                        byte_idx  <= 3'd0;
                        tx_en_q   <= 1'b1;
                        tx_data_q <= SLAVE_ADDR;
                        state     <= SEND;
                    end
                end

                SEND: begin
                    if (bus.TX_Done_Sig) begin
                        tx_en_q <= 1'b0;
                        state   <= NEXT;
                    end
                end

                // One low cycle lets the transmitter's step counter rewind.
                NEXT: begin
                    if (byte_idx == BYTE_LAST) begin
                        gap_cnt <= 6'd0;
                        state   <= GAP;
                    end else begin
                        byte_idx  <= byte_idx + 3'd1;
                        tx_en_q   <= 1'b1;
                        tx_data_q <= frame_byte(byte_idx + 3'd1, data0, crc);
                        state     <= SEND;
                    end
                end

                GAP: begin
                    if (bus.BPS_CLK) begin
                        gap_cnt <= gap_nxt;
                        if (gap_final) begin
                            frame_done_q <= 1'b1;
                            bit_cnt      <= 6'd0;
                            if (pend_vld) begin
                                // Any simultaneous request was already flagged
                                // as dropped above since the slot was full.
                                data0    <= pend_dat;
                                pend_vld <= 1'b0;
                                state    <= CRC;
                            end else if (bus.Req_Sig) begin
                                data0    <= bus.Req_Data;
                                pend_vld <= 1'b0;
                                state    <= CRC;
                            end else begin
                                busy_q <= 1'b0;
                                state  <= IDLE;
                            end
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.TX_En_Sig      = tx_en_q;
    assign bus.TX_Data        = tx_data_q;
    assign bus.Busy_Sig       = busy_q;
    assign bus.Frame_Done_Sig = frame_done_q;
    assign bus.Drop_Sig       = drop_q;

endmodule
